bram_stream_reader: RTL and testbench

- Read-side master for the team's simple dual-port BRAM (write port A, registered read port B).
- On `start`, fetches `len` consecutive words from `base_addr` by driving `addrb` and capturing `bram_dout` after the fixed read latency.
- Presents the words as a valid/ready stream with `m_last`, and absorbs back-pressure with a small skid FIFO.
- Sits between a BRAM-buffered data store and downstream compute (e.g. SpMM/attention feature fetch).

---
 rtl/bram_reader_pkg.sv | 28 ++
 rtl/bram_rd_skid_fifo.sv | 54 +++++
 rtl/bram_stream_reader.sv | 159 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_reader_pkg.sv
// Shared types and latency constants for the BRAM stream reader.
// Optional macro BRAM_RD_LAT2_EN selects a BRAM with an output register (RD_LAT=2).
package bram_reader_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

`ifdef BRAM_RD_LAT2_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  // Enough slots to hold every read that can still land after ready drops.
  localparam int unsigned SKID_DEPTH = RD_LAT + 1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 19;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } beat_t;

  // Address increment that wraps at the end of the memory.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 1 >= depth) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Small register FIFO holding stream beats; simultaneous push and pop on a
// full FIFO is legal and leaves the count unchanged.
module bram_rd_skid_fifo
  import bram_reader_pkg::*;
#(
  parameter type         beat_t = bram_reader_pkg::beat_t,
  parameter int unsigned DEPTH  = SKID_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Head of queue and empty flag.
  always_comb begin
    head  = mem[rd_ptr];
    empty = (count == '0);
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side burst master for a registered-output BRAM: issues len reads from
// base_addr (wrapping modulo DEPTH) and streams the words out with m_last.
// Optional macro BRAM_RD_LAT2_EN: BRAM read latency of 2 instead of 1.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 19,
  parameter int unsigned DEPTH       = 242101,
  parameter int unsigned DATA_ADDR_W = $clog2(DEPTH),
  parameter int unsigned LEN_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_ADDR_W-1:0] addrb,
  output logic                   rd_issue,
  input  logic [DATA_WIDTH-1:0]  bram_dout,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_w_t;

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  state_t           state;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] beat_cnt;

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] limit;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             push;
  logic             pop;
  beat_w_t          fifo_head;
  beat_w_t          in_beat;
  beat_w_t          out_beat;

  // Capture, stream handshake and read-credit logic.
  always_comb begin
    push         = pipe_vld[RD_LAT-1];
    in_beat.data = bram_dout;
    in_beat.last = pipe_last[RD_LAT-1];

    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_vld[i]);

    // Landing word bypasses an empty FIFO so the first beat appears in the
    // cycle bram_dout is valid; it is only stored if not taken this cycle.
    m_valid   = !fifo_empty || push;
    pop       = m_valid && m_ready;
    fifo_push = push && !(fifo_empty && m_ready);
    fifo_pop  = pop && !fifo_empty;
    out_beat  = fifo_empty ? (push ? in_beat : '0) : fifo_head;
    m_data    = out_beat.data;
    m_last    = out_beat.last;

    occ      = OCC_W'(fifo_count) + OCC_W'(inflight);
    limit    = OCC_W'(SKID_DEPTH) + OCC_W'(pop);
    rd_issue = (state == FETCH) && (occ < limit);
  end

  // Read-issue delay line aligned to the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_last[0] <= rd_issue && (issue_cnt == LEN_W'(1));
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // Burst control FSM with registered busy/done/addrb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addrb     <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (pop) beat_cnt <= beat_cnt - 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state     <= FETCH;
              addrb     <= base_addr;
              issue_cnt <= len;
              beat_cnt  <= len;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (rd_issue) begin
            addrb     <= DATA_ADDR_W'(wrap_inc(32'(addrb), DEPTH));
            issue_cnt <= issue_cnt - 1'b1;
            if (issue_cnt == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && beat_cnt == LEN_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_rd_skid_fifo #(
    .beat_t (beat_w_t),
    .DEPTH  (SKID_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_beat (in_beat),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural registered BRAM
// whose word at address a is a+100.
module tb_bram_stream_reader;
  import bram_reader_pkg::*;

  localparam int DW    = 19;
  localparam int DEPTH = 242101;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic          rd_issue;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  bram_stream_reader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .addrb     (addrb),
    .rd_issue  (rd_issue),
    .bram_dout (bram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Registered BRAM read port.
  logic [DW-1:0] b1, b2;
  always @(posedge clk) begin
    b1 <= DW'(addrb) + DW'(100);
    b2 <= b1;
  end
  assign bram_dout = (RD_LAT == 2) ? b2 : b1;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int done_cnt, valid_cnt, issue_n, outstanding;
  bit prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] rx_data[$];
  logic          rx_last[$];
  logic [AW-1:0] rx_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int b, input int i);
    return DW'(((b + i) % DEPTH) + 100);
  endfunction

  function automatic logic rdy(input int mode, input int k);
    return (mode == 0) ? 1'b1 : ((k % 3) == 0);
  endfunction

  task automatic clear_obs();
    rx_data.delete();
    rx_last.delete();
    rx_addr.delete();
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    valid_cnt       = 0;
    issue_n         = 0;
  endtask

  // Observe one cycle (inputs already applied), then advance past the edge.
  task automatic cycle();
    #1;
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    if (m_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
    end
    if (rd_issue) begin
      issue_n++;
      rx_addr.push_back(addrb);
      chk("issue_credit", (outstanding - int'(m_valid && m_ready)) < int'(SKID_DEPTH), 1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
      chk("valid_low_in_done", m_valid, 0);
    end
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
      last_hs_cyc = cyc_n;
      outstanding--;
    end
    if (rd_issue) outstanding++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic burst(input int b, input int l, input int mode, input bit poke_busy);
    int k;
    clear_obs();
    base_addr = AW'(b);
    len       = LW'(l);
    start     = 1'b1;
    m_ready   = rdy(mode, 0);
    start_cyc = cyc_n;
    cycle();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 1;
    while (done_cnt == 0 && k < 400) begin
      m_ready = rdy(mode, k);
      if (poke_busy && k == 2) begin
        start     = 1'b1;
        base_addr = AW'(7);
        len       = LW'(5);
      end else begin
        start = 1'b0;
      end
      cycle();
      k++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    chk("beat_count", rx_data.size(), l);
    chk("issue_count", issue_n, l);
    for (int i = 0; i < rx_data.size() && i < l; i++) begin
      chk("beat_data", rx_data[i], exp_data(b, i));
      chk("beat_last", rx_last[i], (i == l - 1));
    end
    for (int i = 0; i < rx_addr.size() && i < l; i++)
      chk("read_addr", rx_addr[i], (b + i) % DEPTH);
    if (l > 0) begin
      chk("first_valid_latency", first_valid_cyc - start_cyc, RD_LAT + 1);
      chk("done_after_last_beat", done_cyc - last_hs_cyc, 1);
      if (mode == 0) chk("full_throughput", last_hs_cyc - first_valid_cyc, l - 1);
    end else begin
      chk("len0_done_latency", done_cyc - start_cyc, 1);
      chk("len0_no_valid", valid_cnt, 0);
    end
    cycle();
    chk("idle_after_burst", busy, 0);
    chk("single_done", done_cnt, 1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    len        = '0;
    m_ready    = 1'b0;
    prev_stall = 1'b0;
    outstanding = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_rd_issue", rd_issue, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);

    // Basic burst at full rate.
    burst(10, 4, 0, 1'b0);
    // Same burst with back-pressure 1,0,0,1,...
    burst(10, 4, 1, 1'b0);
    // Address wrap at the top of memory.
    burst(DEPTH - 2, 4, 0, 1'b0);
    // Wrap under back-pressure.
    burst(DEPTH - 3, 6, 1, 1'b0);
    // Empty burst.
    burst(0, 0, 0, 1'b0);

    // Reset in the middle of a burst, after two beats.
    clear_obs();
    base_addr = AW'(50);
    len       = LW'(8);
    start     = 1'b1;
    m_ready   = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 20 && rx_data.size() < 2; k++) cycle();
    chk("pre_reset_beats", rx_data.size(), 2);
    m_ready = 1'b0;
    rst     = 1'b1;
    cycle();
    rst         = 1'b0;
    m_ready     = 1'b1;
    outstanding = 0;
    prev_stall  = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_rd_issue", rd_issue, 0);
    chk("midrst_addrb", addrb, 0);
    clear_obs();
    repeat (4) cycle();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_valid", valid_cnt, 0);
    chk("midrst_no_issue", issue_n, 0);

    // Fresh burst; a start while busy must be ignored.
    burst(0, 3, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
